ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_pkg.sv | 65 ++++++
 rtl/ahb_arbiter_if.sv | 39 +++
 rtl/ahb_rr_select.sv | 42 ++++
 rtl/ahb_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ahb_arbiter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB encodings and helpers for the bus arbiter.
//   htrans_t    : transfer type (IDLE, BUSY, NONSEQ, SEQ)
//   hburst_t    : burst type (SINGLE .. INCR16)
//   hresp_t     : slave response (OKAY, ERROR, RETRY, SPLIT)
//   arb_state_t : arbiter FSM states (ARB, BURST)
//   burstBeatsMinusOne() : beat-counter load value for a burst type
//   isFixedBurst()       : true for the 4/8/16-beat burst types
// ---------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int BEAT_CNT_W = 4;

    // Remaining beats after the NONSEQ of a fixed-length burst. SINGLE and
    // INCR have no fixed length, so they map to zero and never start a
    // counted burst.
    function automatic logic [BEAT_CNT_W-1:0] burstBeatsMinusOne(input hburst_t burst);
        logic [BEAT_CNT_W-1:0] beats;
        beats = '0;
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
            default:                      beats = 4'd0;
        endcase
        return beats;
    endfunction

    // A burst is fixed-length exactly when it has beats left to count.
    function automatic logic isFixedBurst(input hburst_t burst);
        return (burstBeatsMinusOne(burst) != '0);
    endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_if
// Arbitration-side AHB signals shared by the arbiter and its environment.
//   HBUSREQ/HLOCK   : per-master request and locked-transfer request
//   HTRANS/HBURST   : transfer and burst type of the address-phase owner
//   HREADY/HRESP    : slave ready and response
//   HGRANT          : one-hot grant (arbiter output)
//   HMASTER         : address-phase owner index (arbiter output)
//   HMASTLOCK       : current address phase is locked (arbiter output)
// Modports: slave = arbiter view, master = bus/environment view.
// ---------------------------------------------------------------------------
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4
) ();
    import ahb_pkg::*;

    localparam int MASTER_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    htrans_t                HTRANS;
    hburst_t                HBURST;
    logic                   HREADY;
    hresp_t                 HRESP;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [MASTER_W-1:0]    HMASTER;
    logic                   HMASTLOCK;

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        output HGRANT, HMASTER, HMASTLOCK
    );

endinterface

// File: rtl/ahb_rr_select.sv
// ---------------------------------------------------------------------------
// ahb_rr_select
// Combinational round-robin selector: finds the first requesting master
// after the last winner, wrapping around, with the last winner itself
// checked last.
//   i_req        : request vector
//   i_lastWinner : index of the most recent requesting winner
//   o_grant      : one-hot selection (all zero when nobody requests)
//   o_index      : index of the selected master
//   o_valid      : at least one master requests
// ---------------------------------------------------------------------------
module ahb_rr_select #(
    parameter int NUM_MASTERS = 4,
    localparam int MASTER_W   = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [MASTER_W-1:0]    i_lastWinner,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic [MASTER_W-1:0]    o_index,
    output logic                   o_valid
);

    logic [MASTER_W-1:0] w_candidate;

    // Walk the masters in priority order starting just after the last
    // winner; the first requester found wins and later ones are ignored.
    always_comb begin
        o_grant     = '0;
        o_index     = '0;
        o_valid     = 1'b0;
        w_candidate = '0;
        for (int offset = 1; offset <= NUM_MASTERS; offset++) begin
            w_candidate = MASTER_W'((int'(i_lastWinner) + offset) % NUM_MASTERS);
            if (!o_valid && i_req[w_candidate]) begin
                o_grant[w_candidate] = 1'b1;
                o_index              = w_candidate;
                o_valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
// AHB bus arbiter with round-robin priority, locked-transfer support and
// fixed-length burst protection.
//   clk    : bus clock, all state on the rising edge
//   HRESET : asynchronous active-high reset
//   bus    : ahb_arbiter_if.slave (requests, transfer info, grant outputs)
// Parameters: NUM_MASTERS (2..16), DEFAULT_MASTER (granted when idle).
// ---------------------------------------------------------------------------
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic         clk,
    input  logic         HRESET,
    ahb_arbiter_if.slave bus
);

    localparam int                     MASTER_W      = $clog2(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MASTER_W-1:0]    DEFAULT_IDX   = MASTER_W'(DEFAULT_MASTER);

    arb_state_t              r_state;
    arb_state_t              w_nextState;
    logic [BEAT_CNT_W-1:0]   r_beatCnt;
    logic [BEAT_CNT_W-1:0]   w_nextBeatCnt;
    logic                    w_arbPoint;

    logic [NUM_MASTERS-1:0]  r_grant;
    logic [NUM_MASTERS-1:0]  w_nextGrant;
    logic [MASTER_W-1:0]     r_lastWinner;
    logic [MASTER_W-1:0]     w_nextLastWinner;
    logic [MASTER_W-1:0]     r_master;
    logic                    r_mastLock;
    logic [MASTER_W-1:0]     w_grantIndex;
    logic                    w_lockHold;

    logic [NUM_MASTERS-1:0]  w_selGrant;
    logic [MASTER_W-1:0]     w_selIndex;
    logic                    w_selValid;

    ahb_rr_select #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_rrSelect (
        .i_req       (bus.HBUSREQ),
        .i_lastWinner(r_lastWinner),
        .o_grant     (w_selGrant),
        .o_index     (w_selIndex),
        .o_valid     (w_selValid)
    );

    // FSM state and beat counter. Reset drops any burst in progress so the
    // first cycle afterwards is an ordinary arbitration cycle.
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            r_state   <= ST_ARB;
            r_beatCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_beatCnt <= w_nextBeatCnt;
        end
    end

    // Next-state logic. In ARB every ready cycle is an arbitration point and
    // a fixed-length NONSEQ starts a counted burst. In BURST the grant is
    // frozen until the last beat's address is accepted; a non-OKAY response
    // ends the burst at once, and a new NONSEQ either restarts the count or
    // drops back to ARB for an unbounded burst. BUSY and wait states leave
    // the counter alone.
    always_comb begin
        w_nextState   = r_state;
        w_nextBeatCnt = r_beatCnt;
        w_arbPoint    = 1'b0;
        case (r_state)
            ST_ARB: begin
                w_arbPoint = bus.HREADY;
                if (bus.HREADY && (bus.HTRANS == HTRANS_NONSEQ) && isFixedBurst(bus.HBURST)) begin
                    w_nextState   = ST_BURST;
                    w_nextBeatCnt = burstBeatsMinusOne(bus.HBURST);
                end
            end
            ST_BURST: begin
                w_arbPoint = bus.HREADY && (bus.HTRANS == HTRANS_SEQ) &&
                             (r_beatCnt == BEAT_CNT_W'(1));
                if (bus.HRESP != HRESP_OKAY) begin
                    w_nextState   = ST_ARB;
                    w_nextBeatCnt = '0;
                end else if (bus.HREADY) begin
                    case (bus.HTRANS)
                        HTRANS_IDLE: begin
                            w_nextState   = ST_ARB;
                            w_nextBeatCnt = '0;
                        end
                        HTRANS_NONSEQ: begin
                            if (isFixedBurst(bus.HBURST)) begin
                                w_nextBeatCnt = burstBeatsMinusOne(bus.HBURST);
                            end else begin
                                w_nextState   = ST_ARB;
                                w_nextBeatCnt = '0;
                            end
                        end
                        HTRANS_SEQ: begin
                            if (r_beatCnt > BEAT_CNT_W'(1)) begin
                                w_nextBeatCnt = r_beatCnt - BEAT_CNT_W'(1);
                            end else begin
                                w_nextState   = ST_ARB;
                                w_nextBeatCnt = '0;
                            end
                        end
                        default: begin
                            w_nextBeatCnt = r_beatCnt;
                        end
                    endcase
                end
            end
            default: begin
                w_nextState   = ST_ARB;
                w_nextBeatCnt = '0;
            end
        endcase
    end

    // Index of the currently granted master, used to load HMASTER and to
    // pick that master's lock bit for HMASTLOCK.
    always_comb begin
        w_grantIndex = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_grantIndex = MASTER_W'(i);
            end
        end
    end

    // Grant decision. A granted master still holding both HLOCK and HBUSREQ
    // keeps the bus. Otherwise the round-robin winner takes it and becomes
    // the new priority reference; with no requests the default master is
    // parked on the bus without disturbing the round-robin order.
    always_comb begin
        w_lockHold       = |(r_grant & bus.HLOCK & bus.HBUSREQ);
        w_nextGrant      = r_grant;
        w_nextLastWinner = r_lastWinner;
        if (w_arbPoint && !w_lockHold) begin
            if (w_selValid) begin
                w_nextGrant      = w_selGrant;
                w_nextLastWinner = w_selIndex;
            end else begin
                w_nextGrant = DEFAULT_GRANT;
            end
        end
    end

    // Grant, priority pointer and address-phase owner registers. HMASTER and
    // HMASTLOCK follow the grant one ready cycle later, matching the point
    // at which the granted master actually drives the address phase.
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            r_grant      <= DEFAULT_GRANT;
            r_lastWinner <= DEFAULT_IDX;
            r_master     <= DEFAULT_IDX;
            r_mastLock   <= 1'b0;
        end else begin
            r_grant      <= w_nextGrant;
            r_lastWinner <= w_nextLastWinner;
            if (bus.HREADY) begin
                r_master   <= w_grantIndex;
                r_mastLock <= bus.HLOCK[w_grantIndex];
            end
        end
    end

    assign bus.HGRANT    = r_grant;
    assign bus.HMASTER   = r_master;
    assign bus.HMASTLOCK = r_mastLock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter
// Directed self-checking bench for ahb_arbiter (4 masters, default 0).
// Each step drives one cycle of bus inputs and queues the outputs expected
// after the next rising edge; checkOutput pops and compares them.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter;
    import ahb_pkg::*;

    localparam int NUM_MASTERS = 4;

    typedef struct {
        string      tag;
        logic [3:0] grant;
        logic [1:0] master;
        logic       mastLock;
    } expect_t;

    logic    clk;
    logic    HRESET;
    int      checkCount = 0;
    int      errorCount = 0;
    expect_t sbQueue[$];

    ahb_arbiter_if #(.NUM_MASTERS(NUM_MASTERS)) bus ();

    ahb_arbiter #(
        .NUM_MASTERS   (NUM_MASTERS),
        .DEFAULT_MASTER(0)
    ) dut (
        .clk   (clk),
        .HRESET(HRESET),
        .bus   (bus.slave)
    );

    // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Queue the outputs expected at the next sampling point.
    task automatic pushExpect(input string tag, input logic [3:0] grant,
                              input logic [1:0] master, input logic mastLock);
        expect_t e;
        e.tag      = tag;
        e.grant    = grant;
        e.master   = master;
        e.mastLock = mastLock;
        sbQueue.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the live outputs.
    task automatic checkOutput();
        expect_t e;
        if (sbQueue.size() == 0) begin
            checkCount++;
            errorCount++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sbQueue.pop_front();
        checkCount++;
        assert (bus.HGRANT === e.grant) else begin
            errorCount++;
            $error("FAIL %s.HGRANT observed=%b expected=%b", e.tag, bus.HGRANT, e.grant);
        end
        checkCount++;
        assert ($onehot(bus.HGRANT) === 1'b1) else begin
            errorCount++;
            $error("FAIL %s.onehot observed=%b expected=one-hot", e.tag, bus.HGRANT);
        end
        checkCount++;
        assert (bus.HMASTER === e.master) else begin
            errorCount++;
            $error("FAIL %s.HMASTER observed=%0d expected=%0d", e.tag, bus.HMASTER, e.master);
        end
        checkCount++;
        assert (bus.HMASTLOCK === e.mastLock) else begin
            errorCount++;
            $error("FAIL %s.HMASTLOCK observed=%b expected=%b", e.tag, bus.HMASTLOCK, e.mastLock);
        end
    endtask

    // Drive one cycle of inputs, queue the post-edge expectation, then
    // sample 1 unit after the rising edge.
    task automatic applyStimulus(input string tag, input logic [3:0] req, input logic [3:0] lock,
                                 input htrans_t trans, input hburst_t burst, input logic ready,
                                 input hresp_t resp, input logic [3:0] expGrant,
                                 input logic [1:0] expMaster, input logic expLock);
        bus.HBUSREQ = req;
        bus.HLOCK   = lock;
        bus.HTRANS  = trans;
        bus.HBURST  = burst;
        bus.HREADY  = ready;
        bus.HRESP   = resp;
        pushExpect(tag, expGrant, expMaster, expLock);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        HRESET      = 1'b1;
        bus.HBUSREQ = '0;
        bus.HLOCK   = '0;
        bus.HTRANS  = HTRANS_IDLE;
        bus.HBURST  = HBURST_SINGLE;
        bus.HREADY  = 1'b1;
        bus.HRESP   = HRESP_OKAY;
        @(posedge clk);
        #1;
        pushExpect("reset", 4'b0001, 2'd0, 1'b0);
        checkOutput();
        HRESET = 1'b0;

        // Round-robin alternation, HMASTER lagging by one ready cycle
        applyStimulus("rr1",   4'b0001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0001, 2'd0, 1'b0);
        applyStimulus("rr2",   4'b0101, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0100, 2'd0, 1'b0);
        applyStimulus("rr3",   4'b0101, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0001, 2'd2, 1'b0);
        applyStimulus("rr4",   4'b0101, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0100, 2'd0, 1'b0);
        applyStimulus("rrWait",4'b0101, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b0, HRESP_OKAY, 4'b0100, 2'd0, 1'b0);
        applyStimulus("rr5",   4'b0101, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0001, 2'd2, 1'b0);

        // No requests parks the bus on the default master
        applyStimulus("idle1", 4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0001, 2'd0, 1'b0);
        applyStimulus("idle2", 4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0001, 2'd0, 1'b0);

        // INCR4 by master 1 with two wait states on beat 2; master 1 drops
        // its request mid-burst and master 2 takes over on the last beat
        applyStimulus("inc4a", 4'b0010, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0010, 2'd0, 1'b0);
        applyStimulus("inc4b", 4'b0010, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0010, 2'd1, 1'b0);
        applyStimulus("inc4N", 4'b0010, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, HRESP_OKAY, 4'b0010, 2'd1, 1'b0);
        applyStimulus("inc4W1",4'b0110, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b0, HRESP_OKAY, 4'b0010, 2'd1, 1'b0);
        applyStimulus("inc4W2",4'b0110, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b0, HRESP_OKAY, 4'b0010, 2'd1, 1'b0);
        applyStimulus("inc4S2",4'b0100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, HRESP_OKAY, 4'b0010, 2'd1, 1'b0);
        applyStimulus("inc4S3",4'b0100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, HRESP_OKAY, 4'b0010, 2'd1, 1'b0);
        applyStimulus("inc4S4",4'b0100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, HRESP_OKAY, 4'b0100, 2'd1, 1'b0);
        applyStimulus("inc4End",4'b0100,4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0100, 2'd2, 1'b0);

        // Locked master 0 keeps the bus; master 1 wins once the lock drops,
        // and a default park does not move the round-robin pointer
        applyStimulus("lock1", 4'b0001, 4'b0001, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0001, 2'd2, 1'b0);
        applyStimulus("lock2", 4'b0111, 4'b0001, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0001, 2'd0, 1'b1);
        applyStimulus("lock3", 4'b0111, 4'b0001, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0001, 2'd0, 1'b1);
        applyStimulus("unlock",4'b0111, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0010, 2'd0, 1'b0);
        applyStimulus("park",  4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0001, 2'd1, 1'b0);
        applyStimulus("ptrKeep",4'b0011,4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0001, 2'd0, 1'b0);

        // INCR8 terminated by an ERROR response on beat 3
        applyStimulus("err1",  4'b0001, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0001, 2'd0, 1'b0);
        applyStimulus("errN",  4'b0001, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8,  1'b1, HRESP_OKAY,  4'b0001, 2'd0, 1'b0);
        applyStimulus("errS2", 4'b0101, 4'b0000, HTRANS_SEQ,    HBURST_INCR8,  1'b1, HRESP_OKAY,  4'b0001, 2'd0, 1'b0);
        applyStimulus("errR1", 4'b0101, 4'b0000, HTRANS_SEQ,    HBURST_INCR8,  1'b0, HRESP_ERROR, 4'b0001, 2'd0, 1'b0);
        applyStimulus("errR2", 4'b0101, 4'b0000, HTRANS_IDLE,   HBURST_INCR8,  1'b1, HRESP_ERROR, 4'b0100, 2'd0, 1'b0);

        // INCR never enters a counted burst
        applyStimulus("incrN", 4'b0101, 4'b0000, HTRANS_NONSEQ, HBURST_INCR, 1'b1, HRESP_OKAY, 4'b0001, 2'd2, 1'b0);
        applyStimulus("incrS", 4'b0101, 4'b0000, HTRANS_SEQ,    HBURST_INCR, 1'b1, HRESP_OKAY, 4'b0100, 2'd0, 1'b0);

        // WRAP4 with a BUSY beat that must not advance the count
        applyStimulus("busy0", 4'b0100, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0100, 2'd2, 1'b0);
        applyStimulus("busyN", 4'b0100, 4'b0000, HTRANS_NONSEQ, HBURST_WRAP4,  1'b1, HRESP_OKAY, 4'b0100, 2'd2, 1'b0);
        applyStimulus("busyS2",4'b0101, 4'b0000, HTRANS_SEQ,    HBURST_WRAP4,  1'b1, HRESP_OKAY, 4'b0100, 2'd2, 1'b0);
        applyStimulus("busyB", 4'b0101, 4'b0000, HTRANS_BUSY,   HBURST_WRAP4,  1'b1, HRESP_OKAY, 4'b0100, 2'd2, 1'b0);
        applyStimulus("busyS3",4'b0101, 4'b0000, HTRANS_SEQ,    HBURST_WRAP4,  1'b1, HRESP_OKAY, 4'b0100, 2'd2, 1'b0);
        applyStimulus("busyS4",4'b0101, 4'b0000, HTRANS_SEQ,    HBURST_WRAP4,  1'b1, HRESP_OKAY, 4'b0001, 2'd2, 1'b0);

        // Locked WRAP16 by master 3, aborted by an asynchronous reset
        applyStimulus("w16a",  4'b1000, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b1000, 2'd0, 1'b0);
        applyStimulus("w16b",  4'b1000, 4'b1000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b1000, 2'd3, 1'b1);
        applyStimulus("w16N",  4'b1000, 4'b1000, HTRANS_NONSEQ, HBURST_WRAP16, 1'b1, HRESP_OKAY, 4'b1000, 2'd3, 1'b1);
        applyStimulus("w16S2", 4'b1001, 4'b1000, HTRANS_SEQ,    HBURST_WRAP16, 1'b1, HRESP_OKAY, 4'b1000, 2'd3, 1'b1);
        HRESET = 1'b1;
        #2;
        pushExpect("asyncReset", 4'b0001, 2'd0, 1'b0);
        checkOutput();
        @(posedge clk);
        #1;
        pushExpect("resetHeld", 4'b0001, 2'd0, 1'b0);
        checkOutput();
        HRESET = 1'b0;

        // First arbitrations after reset start from the default pointer
        applyStimulus("post1", 4'b1001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b1000, 2'd0, 1'b0);
        applyStimulus("post2", 4'b1001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0001, 2'd3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
